// File: rtl/obi_mem_arbiter_if.sv
// Single OBI-style request/response port. The same shape is used for the
// fetcher, the LSU and the shared memory side of the arbiter.
interface obi_mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          proc_req;
    logic          rdy;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          valid;

    modport master (
        output proc_req, addr, we, wdata,
        input  rdy, rdata, valid
    );

    modport slave (
        input  proc_req, addr, we, wdata,
        output rdy, rdata, valid
    );
endinterface

// File: rtl/obi_mem_arbiter.sv
// Shares one in-order memory port between the fetcher (id 0) and the LSU
// (id 1); a small ID FIFO routes each response back to the port that issued it.
//
// state  | meaning
// IDLE   | grant decided each cycle from the current requests
// LOCKED | request presented but not yet accepted; grant held on sel
module obi_mem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_OUT  = 2,
    parameter bit LSU_PRIO = 1'b0
) (
    input  logic                CLK,
    input  logic                RSTn,
    obi_mem_arbiter_if.slave    if_bus,
    obi_mem_arbiter_if.slave    lsu_bus,
    obi_mem_arbiter_if.master   mem_bus,
    output logic                err
);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t               state;
    logic                 sel;
    logic [MAX_OUT-1:0]   id_fifo;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;

    logic                 grant;
    logic                 gnt_req;
    logic                 accept;
    logic                 pop;
    logic                 head;

    // The fetcher never writes, so its write fields are ignored.
    logic                 unused_if_wr;
    assign unused_if_wr = ^{if_bus.we, if_bus.wdata};

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        grant = sel;
        if (state == IDLE) begin
            if (if_bus.proc_req && lsu_bus.proc_req)
                grant = LSU_PRIO ? 1'b1 : ~sel;
            else
                grant = lsu_bus.proc_req;
        end
    end

    assign gnt_req = grant ? lsu_bus.proc_req : if_bus.proc_req;

    // Issue is gated on the registered count only, never on mem_valid.
    assign mem_bus.proc_req = gnt_req && (count < CW'(MAX_OUT));
    assign mem_bus.addr     = gnt_req ? (grant ? lsu_bus.addr : if_bus.addr) : '0;
    assign mem_bus.we       = gnt_req & grant & lsu_bus.we;
    assign mem_bus.wdata    = (gnt_req && grant) ? lsu_bus.wdata : '0;

    assign accept      = mem_bus.proc_req & mem_bus.rdy;
    assign if_bus.rdy  = accept & ~grant;
    assign lsu_bus.rdy = accept & grant;

    assign pop           = mem_bus.valid && (count != '0);
    assign head          = id_fifo[rd_ptr];
    assign if_bus.valid  = pop & ~head;
    assign lsu_bus.valid = pop & head;
    assign if_bus.rdata  = mem_bus.rdata;
    assign lsu_bus.rdata = mem_bus.rdata;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state   <= IDLE;
            sel     <= 1'b1;
            id_fifo <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (mem_bus.proc_req && !mem_bus.rdy) state <= LOCKED;
                LOCKED:  if (accept) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (mem_bus.proc_req)
                sel <= grant;

            if (accept) begin
                id_fifo[wr_ptr] <= grant;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);

            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // A response with nothing outstanding is dropped and flagged.
            if (mem_bus.valid && (count == '0))
                err <= 1'b1;
        end
    end
endmodule

// File: doc/obi_mem_arbiter.md
# obi_mem_arbiter

Two-to-one arbiter that shares the single OBI-style memory port (proc_req / mem_rdy / addr / we / wdata / rdata / valid) between the instruction fetcher and the load/store unit. It sits between the `fetcher` and LSU on one side and the memory wrapper on the other. It does three things: arbitrates requests, holds the grant stable until the memory accepts, and tracks in-flight transactions so each in-order response reaches the requester that issued it.

## Interface
- AW, 32, address width
- DW, 32, data width
- MAX_OUT, 2, maximum accepted-but-unanswered transactions (≥1)
- LSU_PRIO, 0, 0 = round-robin; 1 = LSU always wins a conflict

- CLK  in  1  clock, rising edge
- RSTn  in  1  asynchronous, active-low reset
- if_req  in  1  fetcher request
- if_rdy  out  1  fetcher request accepted this cycle
- if_addr  in  AW  fetcher address
- if_rdata  out  DW  read data (copy of mem_rdata)
- if_valid  out  1  response for fetcher
- lsu_req  in  1  LSU request
- lsu_rdy  out  1  LSU request accepted this cycle
- lsu_addr  in  AW  LSU address
- lsu_we  in  1  LSU write enable
- lsu_wdata  in  DW  LSU write data
- lsu_rdata  out  DW  read data (copy of mem_rdata)
- lsu_valid  out  1  response for LSU
- mem_proc_req  out  1  request to memory
- mem_rdy  in  1  memory accepts request
- mem_addr  out  AW  muxed address
- mem_we  out  1  muxed write enable (0 for fetcher)
- mem_wdata  out  DW  muxed write data (0 for fetcher)
- mem_rdata  in  DW  memory read data
- mem_valid  in  1  memory response
- err  out  1  sticky: mem_valid seen with no transaction outstanding

## Operation
- Handshake: a transfer occurs when proc_req & rdy are high in the same cycle. Requesters hold req/addr/we/wdata stable until accepted. Memory answers in order, with one valid pulse per accepted request.
- Registered state:
  - sel: last or held grant, 0 = IF, 1 = LSU
  - lock flag
  - ID FIFO of depth MAX_OUT, 1-bit entries
  - count, width $clog2(MAX_OUT+1)
  - err
- Grant decision, combinational, only when lock = 0:
  - Only one requester → that one.
  - Both, LSU_PRIO = 1 → LSU.
  - Both, LSU_PRIO = 0 → the port opposite to sel.
- When lock = 1, the grant equals sel regardless of other requests.
- States:
  - IDLE (lock = 0): grant per rules above.
  - LOCKED (lock = 1): entered when mem_proc_req & !mem_rdy; sel captures the grant. Exits on mem_proc_req & mem_rdy.
- sel updates on every accepted transfer.
- Issue gating: mem_proc_req = granted req & (count < MAX_OUT). There is no combinational path from mem_valid to mem_proc_req, so no issue into a full FIFO even if a response pops in the same cycle.
- mem_addr, mem_we and mem_wdata are driven from the granted port. When nothing is granted they are 0.
- if_rdy / lsu_rdy = mem_rdy & mem_proc_req & (grant == port).
- On acceptance, push the grant ID. On mem_valid, pop the head and route it: head = 0 → if_valid, head = 1 → lsu_valid.
- Push and pop in the same cycle: count is unchanged and the FIFO pointers both advance, wrapping modulo MAX_OUT.
- Response routing is combinational: rdata is broadcast to both ports, and valid is gated by the head ID.
- mem_valid with count = 0: set err (sticky until reset). No valid is asserted, and count stays at 0 (no underflow).

## Timing
- Reset values:
  - Registers: sel = 1 (IF wins the first conflict), lock = 0, count = 0, FIFO pointers = 0, err = 0.
  - Outputs: all outputs 0.
- Request path: zero cycles. Requester → memory is combinational, and rdy is combinational from mem_rdy.
- Response path: zero cycles. mem_valid → port valid in the same cycle.
- Arbiter adds no latency beyond the memory's own.
- Reset asserted mid-transaction clears the lock and the FIFO immediately; in-flight responses are dropped. The memory shares RSTn, so no stale responses arrive after reset.
- Throughput: one request per cycle while count < MAX_OUT. With MAX_OUT = 1, accepts alternate with responses.

## Test plan
- **IF-only stream:** if_req held at addresses 0x00400000, +4, +8; mem_rdy = 1; 1-cycle memory. Expect mem_addr to follow, if_rdy = 1 each cycle, and three if_valid pulses; lsu_valid stays 0.
- **Conflict, round-robin:** if_req and lsu_req high together from reset, mem_rdy = 1. Expect grant order IF, LSU, IF, LSU. Responses routed to match; mem_we = 1 only in LSU write cycles.
- **Lock:** LSU requests, mem_rdy = 0 for 3 cycles, if_req rises in cycle 2. Expect the grant to stay on LSU (mem_addr = lsu_addr) until mem_rdy, then IF is granted the next cycle.
- **Full FIFO (MAX_OUT = 2):** memory withholds valid. Expect 2 accepts, then mem_proc_req = 0 with both rdy = 0. On the first mem_valid, count drops to 1, and issue resumes the following cycle.
- **Spurious valid:** mem_valid pulse with count = 0. Expect err = 1 and held, both port valids 0, count stays 0; err clears only after RSTn.
- **LSU_PRIO = 1:** both requesting continuously. Expect LSU granted every cycle and IF starved.
